uart_ctrl: RTL

//  CPU-side controller for the async_transmitter/async_receiver pair. Exposes a data and a status register on a simple load/store bus.

---
 rtl/uart_ctrl_pkg.sv | 34 +++
 rtl/uart_fifo.sv | 56 +++++
 rtl/uart_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared register map, status bit layout and TX sequencer states for uart_ctrl.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package uart_ctrl_pkg;

  // Register offsets on the one-bit bus address
  localparam logic UART_DATA = 1'b0;
  localparam logic UART_STAT = 1'b1;

  // Status register bit positions
  localparam int ST_TXNF   = 0;
  localparam int ST_RXNE   = 1;
  localparam int ST_TXDONE = 2;
  localparam int ST_OVR    = 3;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_START = 2'd1,
    T_WAIT  = 2'd2
  } txState_e;

  // Assemble the status byte; upper nibble always reads zero
  function automatic logic [7:0] makeStatus(input logic txNotFull, input logic rxNotEmpty,
                                            input logic txDone, input logic rxOverrun);
    logic [7:0] s;
    s            = 8'h00;
    s[ST_TXNF]   = txNotFull;
    s[ST_RXNE]   = rxNotEmpty;
    s[ST_TXDONE] = txDone;
    s[ST_OVR]    = rxOverrun;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with combinational head output and occupancy count.
// Latency: a pushed byte is visible at dout the cycle after the push.
// Backpressure: push refused while full (judged on start-of-cycle occupancy); pop ignored while empty.
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          doPush;
  logic          doPop;

  // A full FIFO refuses a push even when it also pops this cycle
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign dout   = mem[rdPtr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// CPU-side UART controller: DATA/STATUS registers, TX/RX byte FIFOs, TxD_start sequencing, RxD drain.
// Latency: bus_rdata one cycle after a read strobe; tx_start one cycle after a byte reaches an idle TX head.
// Backpressure: writes to a full TX FIFO and bytes arriving at a full RX FIFO are dropped (the latter flags overrun).
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_en,
  input  logic       bus_we,
  input  logic       bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       rx_clear
);

  logic                      busRead;
  logic                      txPush;
  logic                      txPop;
  logic                      txFull;
  logic                      txEmpty;
  logic [7:0]                txHead;
  logic [$clog2(TX_DEPTH):0] txCount;
  logic                      rxPush;
  logic                      rxPop;
  logic                      rxFull;
  logic                      rxEmpty;
  logic [7:0]                rxHead;
  logic [$clog2(RX_DEPTH):0] rxCount;
  logic                      overrun;
  logic                      ovrClear;
  logic                      txDone;
  logic [7:0]                status;
  txState_e                  txState;
  txState_e                  txNext;
  logic                      txStartNext;
  logic [7:0]                txDataNext;

  assign busRead  = bus_en & ~bus_we;
  assign txPush   = bus_en & bus_we & (bus_addr == UART_DATA);
  assign ovrClear = bus_en & bus_we & (bus_addr == UART_STAT) & bus_wdata[ST_OVR];
  assign rxPop    = busRead & (bus_addr == UART_DATA) & ~rxEmpty;
  // A new receiver byte is taken only on the first cycle of rx_ready, before rx_clear answers it
  assign rxPush   = rx_ready & ~rx_clear;

  // Done means nothing queued, sequencer parked and the transmitter line quiet
  assign txDone = (txCount == '0) & (txState == T_IDLE) & ~tx_busy;
  assign status = makeStatus(~txFull, (rxCount != '0), txDone, overrun);

  uart_fifo #(.DEPTH(TX_DEPTH)) txFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (txPush),
    .pop   (txPop),
    .din   (bus_wdata),
    .dout  (txHead),
    .full  (txFull),
    .empty (txEmpty),
    .count (txCount)
  );

  uart_fifo #(.DEPTH(RX_DEPTH)) rxFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rxPush),
    .pop   (rxPop),
    .din   (rx_data),
    .dout  (rxHead),
    .full  (rxFull),
    .empty (rxEmpty),
    .count (rxCount)
  );

  // TX sequencer next state; start only from idle with busy low, so start never overlaps busy
  always_comb begin
    txNext      = txState;
    txPop       = 1'b0;
    txStartNext = 1'b0;
    txDataNext  = tx_data;
    case (txState)
      T_IDLE: begin
        if (!txEmpty && !tx_busy) begin
          txNext      = T_START;
          txPop       = 1'b1;
          txStartNext = 1'b1;
          txDataNext  = txHead;
        end
      end
      // Busy rises one cycle after the start pulse, so skip a cycle before watching it
      T_START: txNext = T_WAIT;
      T_WAIT:  if (!tx_busy) txNext = T_IDLE;
      default: txNext = T_IDLE;
    endcase
  end

  // TX sequencer state and its registered transmitter outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState  <= T_IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      txState  <= txNext;
      tx_start <= txStartNext;
      tx_data  <= txDataNext;
    end
  end

  // One-cycle clear pulse per received byte, plus sticky overrun (a new overrun beats a clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_clear <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rx_clear <= rxPush;
      if (rxPush && rxFull) overrun <= 1'b1;
      else if (ovrClear)    overrun <= 1'b0;
    end
  end

  // Read data register; an empty DATA read returns zero and holds until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata <= 8'h00;
    end else if (busRead) begin
      if (bus_addr == UART_STAT) bus_rdata <= status;
      else if (rxEmpty)          bus_rdata <= 8'h00;
      else                       bus_rdata <= rxHead;
    end
  end

endmodule
